// File: rtl/dmem_req_ctrl_pkg.sv
// Shared encodings for the data-memory request controller: FSM states, bus size codes,
// reset level and the zero word.
package dmem_req_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

endpackage

// File: rtl/dmem_req_ctrl.sv
// Sequences memory-stage loads/stores onto the SRAM-like data bus, stalls the pipeline while
// an access is outstanding, captures load data, and drains flushed accesses without dropping
// the request.
module dmem_req_ctrl
    import dmem_req_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              mem_req_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] dm_o,
    output logic              dm_valid_o
);

    state_t state, state_nxt;
    logic   cancel, cancel_nxt;
    logic   cancel_eff;
    logic   issue;
    logic   capture;

    // A flush arriving in the same cycle as data_ok must already count as cancelled.
    assign cancel_eff = cancel | flush_i;

    always_comb begin
        state_nxt  = state;
        cancel_nxt = cancel;
        issue      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i && !flush_i) begin
                    issue     = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (flush_i) cancel_nxt = 1'b1;
                if (data_addr_ok_i) begin
                    if (data_data_ok_i) begin
                        if (cancel_eff) begin
                            state_nxt  = IDLE;
                            cancel_nxt = 1'b0;
                        end else begin
                            state_nxt = DONE;
                            capture   = ~data_wr_o;
                        end
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (flush_i) cancel_nxt = 1'b1;
                if (data_data_ok_i) begin
                    if (cancel_eff) begin
                        state_nxt  = IDLE;
                        cancel_nxt = 1'b0;
                    end else begin
                        state_nxt = DONE;
                        capture   = ~data_wr_o;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                cancel_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state        <= IDLE;
            cancel       <= 1'b0;
            data_wr_o    <= 1'b0;
            data_size_o  <= '0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
            dm_o         <= DATA_W'(ZERO_WORD);
        end else begin
            state  <= state_nxt;
            cancel <= cancel_nxt;
            if (issue) begin
                data_wr_o    <= mem_wr_i;
                data_size_o  <= mem_size_i;
                data_addr_o  <= mem_addr_i;
                data_wdata_o <= mem_wdata_i;
            end
            if (capture) dm_o <= data_rdata_i;
        end
    end

    // Request is a pure function of the registered state, so it rises the cycle after issue.
    assign data_req_o = (state == ADDR);
    assign dm_valid_o = (state == DONE) & ~flush_i;
    assign stall_o    = (mem_req_i & ~flush_i & (state != DONE))
                      | ((state != IDLE) & cancel & mem_req_i);

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: cycle tables per scenario plus a scoreboard of
// expected dm words checked whenever dm_valid_o fires.
module tb_dmem_req_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_req, mem_wr, flush;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              addr_ok, data_ok;
    logic [DATA_W-1:0] rdata;

    logic              data_req_o, data_wr_o, stall_o, dm_valid_o;
    logic [1:0]        data_size_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [DATA_W-1:0] data_wdata_o, dm_o;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .cpu_clk_50M   (clk),
        .cpu_rst_n     (rst_n),
        .mem_req_i     (mem_req),
        .mem_wr_i      (mem_wr),
        .mem_size_i    (mem_size),
        .mem_addr_i    (mem_addr),
        .mem_wdata_i   (mem_wdata),
        .flush_i       (flush),
        .data_req_o    (data_req_o),
        .data_wr_o     (data_wr_o),
        .data_size_o   (data_size_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_addr_ok_i(addr_ok),
        .data_data_ok_i(data_ok),
        .data_rdata_i  (rdata),
        .stall_o       (stall_o),
        .dm_o          (dm_o),
        .dm_valid_o    (dm_valid_o)
    );

    // Scoreboard: every completed access pops the dm word the bench expects to see.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dm_valid_o === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL dm_valid_unexpected: dm_valid_o=1 dm_o=%h, no completion expected", dm_o);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (dm_o !== e) begin
                    fails++;
                    $display("FAIL dm_word: got %h expected %h", dm_o, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = '0;
        mem_wdata = '0;
        flush     = 1'b0;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        step();
        step();
        @(negedge clk);
        tests++;
        if ({data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, dm_o, dm_valid_o, stall_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: req=%b wr=%b size=%0d addr=%h wdata=%h dm=%h valid=%b stall=%b, all required 0",
                     data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, dm_o, dm_valid_o, stall_o);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_word();
        bit ao[6] = '{0, 0, 1, 0, 0, 0};
        bit dk[6] = '{0, 0, 0, 0, 1, 0};
        bit er[6] = '{0, 1, 1, 0, 0, 0};
        bit es[6] = '{1, 1, 1, 1, 1, 0};
        bit ev[6] = '{0, 0, 0, 0, 0, 1};
        mem_req  = 1'b1;
        mem_wr   = 1'b0;
        mem_size = 2'd2;
        mem_addr = 32'h0000_1000;
        rdata    = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        for (int c = 0; c < 6; c++) begin
            addr_ok = ao[c];
            data_ok = dk[c];
            @(negedge clk);
            tests++;
            if (data_req_o !== er[c] || stall_o !== es[c] || dm_valid_o !== ev[c]) begin
                fails++;
                $display("FAIL load_word_c%0d: req=%b stall=%b valid=%b expected req=%b stall=%b valid=%b",
                         c, data_req_o, stall_o, dm_valid_o, er[c], es[c], ev[c]);
            end
            if (c == 1) begin
                tests++;
                if (data_addr_o !== 32'h0000_1000 || data_size_o !== 2'd2 || data_wr_o !== 1'b0) begin
                    fails++;
                    $display("FAIL load_word_bus: addr=%h size=%0d wr=%b expected 00001000/2/0",
                             data_addr_o, data_size_o, data_wr_o);
                end
            end
            step();
        end
        mem_req = 1'b0;
        step();
    endtask

    task automatic test_store_byte();
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_size  = 2'd0;
        mem_addr  = 32'h0000_1003;
        mem_wdata = 32'h1100_0000;
        rdata     = 32'h5555_5555;
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        addr_ok = 1'b1;
        data_ok = 1'b1;
        @(negedge clk);
        tests++;
        if (data_req_o !== 1'b1 || data_wr_o !== 1'b1 || data_size_o !== 2'd0 ||
            data_addr_o !== 32'h0000_1003 || data_wdata_o !== 32'h1100_0000) begin
            fails++;
            $display("FAIL store_byte_bus: req=%b wr=%b size=%0d addr=%h wdata=%h expected 1/1/0/00001003/11000000",
                     data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o);
        end
        step();
        addr_ok = 1'b0;
        data_ok = 1'b0;
        @(negedge clk);
        tests++;
        if (dm_valid_o !== 1'b1 || stall_o !== 1'b0 || dm_o !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL store_byte_done: valid=%b stall=%b dm=%h expected 1/0/deadbeef",
                     dm_valid_o, stall_o, dm_o);
        end
        mem_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_addr_hold();
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_size  = 2'd2;
        mem_addr  = 32'h0000_2000;
        mem_wdata = 32'hA5A5_5A5A;
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        // Upstream values change while the access is pending; the bus must not follow them.
        mem_addr  = 32'h0000_2FFC;
        mem_wdata = 32'h0F0F_0F0F;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if (data_req_o !== 1'b1 || data_addr_o !== 32'h0000_2000 ||
                data_wdata_o !== 32'hA5A5_5A5A || stall_o !== 1'b1) begin
                fails++;
                $display("FAIL addr_hold_c%0d: req=%b addr=%h wdata=%h stall=%b expected 1/00002000/a5a55a5a/1",
                         c, data_req_o, data_addr_o, data_wdata_o, stall_o);
            end
            step();
        end
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        @(negedge clk);
        tests++;
        if (dm_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL addr_hold_done: valid=%b expected 1", dm_valid_o);
        end
        mem_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_flush_data();
        bit mr[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        bit fl[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        bit ao[8] = '{0, 1, 0, 0, 0, 0, 1, 0};
        bit dk[8] = '{0, 0, 0, 0, 1, 0, 1, 0};
        bit er[8] = '{0, 1, 0, 0, 0, 0, 1, 0};
        bit es[8] = '{1, 1, 0, 0, 0, 1, 1, 0};
        bit ev[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        mem_wr   = 1'b0;
        mem_size = 2'd2;
        mem_addr = 32'h0000_3000;
        for (int c = 0; c < 8; c++) begin
            mem_req = mr[c];
            flush   = fl[c];
            addr_ok = ao[c];
            data_ok = dk[c];
            rdata   = (c == 6) ? 32'hCAFE_0001 : 32'h1234_5678;
            if (c == 5) begin
                mem_addr = 32'h0000_3004;
                exp_q.push_back(32'hCAFE_0001);
            end
            @(negedge clk);
            tests++;
            if (data_req_o !== er[c] || stall_o !== es[c] || dm_valid_o !== ev[c]) begin
                fails++;
                $display("FAIL flush_data_c%0d: req=%b stall=%b valid=%b expected req=%b stall=%b valid=%b",
                         c, data_req_o, stall_o, dm_valid_o, er[c], es[c], ev[c]);
            end
            if (c == 5) begin
                tests++;
                if (dm_o !== 32'hDEAD_BEEF) begin
                    fails++;
                    $display("FAIL flush_data_hold: dm=%h expected deadbeef", dm_o);
                end
            end
            step();
        end
        mem_req = 1'b0;
        step();
    endtask

    task automatic test_drain_new_req();
        bit fl[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        bit ao[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        bit dk[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        bit er[10] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 0};
        bit es[10] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        mem_req  = 1'b1;
        mem_wr   = 1'b0;
        mem_size = 2'd2;
        mem_addr = 32'h0000_4000;
        for (int c = 0; c < 10; c++) begin
            flush   = fl[c];
            addr_ok = ao[c];
            data_ok = dk[c];
            rdata   = (c == 8) ? 32'h0BAD_F00D : 32'hFFFF_FFFF;
            if (c == 2) begin
                mem_addr = 32'h0000_5000;
                exp_q.push_back(32'h0BAD_F00D);
            end
            @(negedge clk);
            tests++;
            if (data_req_o !== er[c] || stall_o !== es[c]) begin
                fails++;
                $display("FAIL drain_c%0d: req=%b stall=%b expected req=%b stall=%b",
                         c, data_req_o, stall_o, er[c], es[c]);
            end
            if (c == 7) begin
                tests++;
                if (dm_o !== 32'hCAFE_0001 || dm_valid_o !== 1'b0) begin
                    fails++;
                    $display("FAIL drain_cancelled: dm=%h valid=%b expected cafe0001/0", dm_o, dm_valid_o);
                end
            end
            if (c == 8) begin
                tests++;
                if (data_addr_o !== 32'h0000_5000) begin
                    fails++;
                    $display("FAIL drain_new_addr: addr=%h expected 00005000", data_addr_o);
                end
            end
            step();
        end
        mem_req = 1'b0;
        step();
    endtask

    task automatic test_flush_idle_done();
        mem_req  = 1'b1;
        mem_wr   = 1'b0;
        mem_size = 2'd1;
        mem_addr = 32'h0000_6002;
        flush    = 1'b1;
        @(negedge clk);
        tests++;
        if (stall_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle_stall: stall=%b expected 0", stall_o);
        end
        step();
        mem_req = 1'b0;
        flush   = 1'b0;
        @(negedge clk);
        tests++;
        if (data_req_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle_issue: req=%b expected 0", data_req_o);
        end
        step();
        mem_req  = 1'b1;
        mem_addr = 32'h0000_7000;
        mem_size = 2'd2;
        step();
        addr_ok = 1'b1;
        data_ok = 1'b1;
        rdata   = 32'h7777_7777;
        step();
        addr_ok = 1'b0;
        data_ok = 1'b0;
        mem_req = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        tests++;
        if (dm_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_done: valid=%b stall=%b expected 0/0", dm_valid_o, stall_o);
        end
        step();
        flush = 1'b0;
        @(negedge clk);
        tests++;
        if (data_req_o !== 1'b0 || dm_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_done_idle: req=%b valid=%b expected 0/0", data_req_o, dm_valid_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_size  = 2'd2;
        mem_addr  = 32'h0000_8000;
        mem_wdata = 32'h1357_9BDF;
        step();
        rst_n   = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        tests++;
        if (data_req_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pre: req=%b expected 1", data_req_o);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, dm_o, dm_valid_o, stall_o} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: req=%b wr=%b size=%0d addr=%h wdata=%h dm=%h valid=%b stall=%b, all required 0",
                     data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, dm_o, dm_valid_o, stall_o);
        end
        step();
        @(negedge clk);
        tests++;
        if (data_req_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_idle: req=%b expected 0", data_req_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_addr_hold();
        test_flush_data();
        test_drain_new_req();
        test_flush_idle_done();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected completions never seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_req_ctrl.md
Name: dmem_req_ctrl

Overview:
- Sequences every data-memory access from the memory stage onto the SRAM-like data bus (req / addr_ok / data_ok handshake) that feeds the AXI bridge.
- Generates the pipeline stall while an access is outstanding.
- Captures read data and holds it as the dm word that the writeback stage byte-selects and extends.
- Squashes accesses cancelled by an exception flush without corrupting the bus protocol.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data-bus data width

Ports:
- cpu_clk_50M  input  1  clock
- cpu_rst_n  input  1  synchronous active-low reset
- mem_req_i  input  1  memory stage holds a valid load/store
- mem_wr_i  input  1  1 = store, 0 = load
- mem_size_i  input  2  0 = byte, 1 = half, 2 = word
- mem_addr_i  input  ADDR_W  byte address
- mem_wdata_i  input  DATA_W  store data, already lane-aligned
- flush_i  input  1  exception flush; cancels the current access
- data_req_o  output  1  bus request
- data_wr_o  output  1  bus write
- data_size_o  output  2  bus size
- data_addr_o  output  ADDR_W  bus address
- data_wdata_o  output  DATA_W  bus write data
- data_addr_ok_i  input  1  address accepted
- data_data_ok_i  input  1  data returned / write done
- data_rdata_i  input  DATA_W  read data
- stall_o  output  1  freeze the pipeline
- dm_o  output  DATA_W  captured load word, to writeback
- dm_valid_o  output  1  access complete this cycle

Behaviour:
- Clock and reset: single clock cpu_clk_50M. Reset is synchronous and active-low on cpu_rst_n.
- Reset values: state = IDLE, cancel = 0, data_req_o = 0, data_wr_o = 0, data_size_o = 0, data_addr_o = 0, data_wdata_o = 0, dm_o = 0, dm_valid_o = 0, stall_o = 0. A reset mid-transaction abandons it; the bus side is reset on the same edge.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If mem_req_i = 1 and flush_i = 0, register wr/size/addr/wdata onto the bus outputs and go to ADDR. data_req_o = 1 from the next cycle (1-cycle issue latency).
  - If flush_i = 1, no access is started.
- ADDR:
  - data_req_o = 1, and all bus outputs are held stable until data_addr_ok_i.
  - On addr_ok: go to DATA.
  - On addr_ok and data_ok together: treat as both events; go directly to DONE, or to IDLE if cancelled.
- DATA:
  - data_req_o = 0.
  - On data_ok with cancel = 0: latch dm_o <= data_rdata_i (loads only; stores leave dm_o unchanged) and go to DONE.
  - On data_ok with cancel = 1: go to IDLE, clear cancel, leave dm_o untouched, and never raise dm_valid_o.
- DONE:
  - dm_valid_o = 1 (registered) for exactly one cycle and stall_o = 0, so the pipeline advances. Next state is IDLE.
  - A new mem_req_i is not accepted in DONE; it is the next instruction and is accepted in IDLE the following cycle.
- Flush:
  - flush_i in ADDR or DATA sets cancel. The request is still held until addr_ok (no request withdrawal), and data_ok is still awaited.
  - flush_i in DONE suppresses dm_valid_o.
  - flush_i in IDLE suppresses issue.
- stall_o (combinational) = mem_req_i & ~flush_i & (state != DONE), OR (state != IDLE & cancel & mem_req_i). A fresh access after a flush therefore waits until the cancelled one drains.
- Hold rule: dm_o holds its value until the next non-cancelled load completes.
- Outstanding accesses: at most one; no pipelining of bus accesses.
- Address alignment: none; misaligned-address exceptions are detected upstream.

Decomposition:
- Shared defines: state encodings (IDLE/ADDR/DATA/DONE), size codes (SIZE_BYTE/SIZE_HALF/SIZE_WORD), RST_ENABLE, ZERO_WORD.
- No sub-module. The FSM plus the capture registers sit in one file.

Test Plan:
- Load, word at 0x0000_1000; addr_ok on cycle 2 and data_ok on cycle 4, rdata = 0xDEAD_BEEF. Expected: data_req_o high on cycles 1–2, stall_o high on cycles 0–4, dm_o = 0xDEADBEEF and dm_valid_o = 1 on cycle 5, stall_o low on cycle 5.
- Store, byte at 0x0000_1003, wdata 0x1100_0000; addr_ok and data_ok both on the first req cycle. Expected: data_size_o = 0 and data_wr_o = 1; DONE on the next cycle; dm_o unchanged.
- Bus outputs stable while addr_ok is withheld for 10 cycles. Expected: data_req_o, data_addr_o and data_wdata_o constant throughout; stall_o stays 1.
- flush_i pulsed in DATA of a load returning 0x1234_5678. Expected: dm_o keeps its prior 0xDEADBEEF, dm_valid_o never rises, and the FSM returns to IDLE on data_ok.
- New mem_req_i during a cancelled drain. Expected: stall_o = 1 until the drain's data_ok; the new request is issued the cycle after IDLE is reached.
- cpu_rst_n low for 1 cycle while in ADDR. Expected: all outputs zero on the next edge, state = IDLE.
